// File: rtl/bufplay.sv
// bufplay: single-clock playback buffer.
// The host fills an internal memory through a DWW-wide write port while idle.
// On start, the block streams DWR-wide words out, one read per sample strobe.
// Two-cycle read path: the address is registered, then the data is registered.
// Optional feature: define BUFPLAY_ZEROFILL_EN to force dout to 0 whenever dvalid is low.
// Otherwise dout holds the last delivered word.
module bufplay #(
    parameter  int DWW = 32,
    parameter  int DWR = 8,
    parameter  int AWW = 8,
    localparam int AWR = (DWW > DWR) ? AWW + $clog2(DWW / DWR) : AWW - $clog2(DWR / DWW)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [DWW-1:0] wdata,
    input  logic [AWW-1:0] waddr,
    input  logic           wen,
    input  logic           start,
    input  logic           stop,
    input  logic [AWR:0]   len,
    input  logic           loop,
    input  logic           stb,
    output logic [DWR-1:0] dout,
    output logic           dvalid,
    output logic           busy,
    output logic           done
);
    // Storage is kept in units of the narrower port width, so both port views
    // become plain groups of consecutive units (lowest address in the LSBs).
    localparam int NW       = (DWW < DWR) ? DWW : DWR;
    localparam int WR_RATIO = DWW / NW;
    localparam int RD_RATIO = DWR / NW;
    localparam int NAW      = AWW + $clog2(WR_RATIO);
    localparam int NDEPTH   = 1 << NAW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state_q;
    logic [AWR-1:0] rptr_q;
    logic [AWR:0]   len_q;
    logic           loop_q;
    logic           done_q;
    logic           vld_p0_q;
    logic [AWR-1:0] raddr_p0_q;
    logic           vld_p1_q;
    logic [DWR-1:0] dout_p1_q;
    logic [DWR-1:0] dout_d;
    logic [NW-1:0]  mem_q [NDEPTH];

    logic           wr_en;
    logic           issue;
    logic [AWR:0]   rptr_inc;
    logic           last_word;

    // Writes only land while idle, so playback never sees data change under it.
    assign wr_en = wen && (state_q == IDLE);

    // A read is issued on a strobe in RUN, unless stop arrives the same cycle.
    assign issue = (state_q == RUN) && stb && !stop;

    // len_q == 0 stands for the full read depth: that is the read where the pointer wraps.
    assign rptr_inc  = {1'b0, rptr_q} + (AWR + 1)'(1);
    assign last_word = (rptr_inc == len_q) || ((len_q == '0) && rptr_inc[AWR]);

    // Host write port: one DWW word spreads over WR_RATIO consecutive storage units.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < WR_RATIO; i++) begin
                mem_q[NAW'(WR_RATIO * int'(waddr) + i)] <= wdata[i*NW +: NW];
            end
        end
    end

    // Read data assembled from RD_RATIO consecutive units at the registered address.
    always_comb begin
        dout_d = '0;
        for (int j = 0; j < RD_RATIO; j++) begin
            dout_d[j*NW +: NW] = mem_q[NAW'(RD_RATIO * int'(raddr_p0_q) + j)];
        end
    end

    // Playback control: start/stop handling, read pointer, drain and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rptr_q   <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            done_q   <= 1'b0;
            vld_p0_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            vld_p0_q <= issue;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q <= RUN;
                        len_q   <= len;
                        loop_q  <= loop;
                        rptr_q  <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // With a read still in the address stage, let it finish first.
                        if (vld_p0_q) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end else if (stb) begin
                        if (last_word) begin
                            rptr_q <= '0;
                            if (!loop_q) begin
                                state_q <= DRAIN;
                            end
                        end else begin
                            rptr_q <= rptr_inc[AWR-1:0];
                        end
                    end
                end
                DRAIN: begin
                    // The final read leaves the address stage; done lands after its dvalid.
                    if (!vld_p0_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ---- stage p0: registered read address ----
    always_ff @(posedge clk) begin
        if (issue) begin
            raddr_p0_q <= rptr_q;
        end
    end

    // ---- stage p1: registered read data and its valid ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1_q  <= 1'b0;
            dout_p1_q <= '0;
        end else begin
            vld_p1_q <= vld_p0_q;
`ifdef BUFPLAY_ZEROFILL_EN
            dout_p1_q <= vld_p0_q ? dout_d : '0;
`else
            if (vld_p0_q) begin
                dout_p1_q <= dout_d;
            end
`endif
        end
    end

    assign dout   = dout_p1_q;
    assign dvalid = vld_p1_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;

endmodule

// File: tb/tb_bufplay.sv
// Scoreboard bench for bufplay: a transaction-level model predicts each
// delivered word and the cycle it is due, plus busy/done per cycle.
module tb_bufplay;
    localparam int DWW   = 32;
    localparam int DWR   = 8;
    localparam int AWW   = 8;
    localparam int AWR   = (DWW > DWR) ? AWW + $clog2(DWW / DWR) : AWW - $clog2(DWR / DWW);
    localparam int R     = DWW / DWR;
    localparam int DEPTH = 1 << AWR;

    logic           clk = 1'b0;
    logic           reset;
    logic [DWW-1:0] wdata;
    logic [AWW-1:0] waddr;
    logic           wen;
    logic           start;
    logic           stop;
    logic [AWR:0]   len;
    logic           loop;
    logic           stb;
    logic [DWR-1:0] dout;
    logic           dvalid;
    logic           busy;
    logic           done;

    bufplay #(.DWW(DWW), .DWR(DWR), .AWW(AWW)) dut (
        .clk(clk), .reset(reset), .wdata(wdata), .waddr(waddr), .wen(wen),
        .start(start), .stop(stop), .len(len), .loop(loop), .stb(stb),
        .dout(dout), .dvalid(dvalid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DWR-1:0] d;
        int             due;
    } item_t;

    item_t          exp_q[$];
    logic [DWR-1:0] bmem [DEPTH];
    int             vectors = 0;
    int             fails = 0;
    int             cyc = 0;
    int             tmo_req = 0;
    int             tmo_seen = 0;
    bit             playing = 0;
    bit             ending = 0;
    bit             mloop = 0;
    int             pos = 0;
    int             cnt = 0;
    int             len_eff = 0;
    int             last_due = 0;
    int             end_due = 0;
    bit             exp_busy = 0;
    bit             exp_done = 0;
    logic [DWR-1:0] last_d = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
        end
    endtask

    // Reference model: one pass per clock over the sampled inputs.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            playing  = 0;
            ending   = 0;
            last_due = 0;
            exp_busy = 0;
            exp_done = 0;
        end else begin
            bit idle;
            idle = !playing && !(ending && cyc < end_due);
            if (idle) begin
                ending = 0;
                if (wen) begin
                    for (int k = 0; k < R; k++) bmem[int'(waddr) * R + k] = wdata[k*DWR +: DWR];
                end
                if (start && !stop) begin
                    playing  = 1;
                    pos      = 0;
                    cnt      = 0;
                    len_eff  = (len == 0) ? DEPTH : int'(len);
                    mloop    = loop;
                    last_due = 0;
                end
            end else if (playing) begin
                if (stop) begin
                    playing = 0;
                    ending  = 1;
                    end_due = (last_due + 1 > cyc + 1) ? last_due + 1 : cyc + 1;
                end else if (stb) begin
                    exp_q.push_back('{d: bmem[pos], due: cyc + 2});
                    last_due = cyc + 2;
                    cnt++;
                    pos = (pos + 1) % DEPTH;
                    if (cnt == len_eff) begin
                        if (mloop) begin
                            pos = 0;
                            cnt = 0;
                        end else begin
                            playing = 0;
                            ending  = 1;
                            end_due = cyc + 3;
                        end
                    end
                end
            end
            cyc++;
            exp_busy = playing || (ending && cyc < end_due);
            exp_done = ending && (cyc == end_due);
        end
    end

    // Monitor: compares DUT outputs against the model on the falling edge.
    always @(negedge clk) begin
        if (tmo_req != tmo_seen) begin
            chk("play_timeout", tmo_req, tmo_seen);
            tmo_seen = tmo_req;
        end
        if (reset) begin
            chk("rst_dvalid", 32'(dvalid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_dout", 32'(dout), 0);
            last_d = '0;
        end else begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            if (dvalid) begin
                if (exp_q.size() == 0) begin
                    chk("dvalid_unexpected", 32'(dvalid), 0);
                end else begin
                    item_t it;
                    it = exp_q.pop_front();
                    chk("dvalid_cycle", cyc, it.due);
                    chk("dout", 32'(dout), 32'(it.d));
                    last_d = it.d;
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    chk("dvalid_missing", 32'(dvalid), 1);
                    void'(exp_q.pop_front());
                end
`ifdef BUFPLAY_ZEROFILL_EN
                chk("dout_gap_zero", 32'(dout), 0);
`else
                chk("dout_gap_hold", 32'(dout), 32'(last_d));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        start = 0;
        stop  = 0;
        wen   = 0;
    endtask

    task automatic wr(input logic [AWW-1:0] a, input logic [DWW-1:0] d);
        wen   = 1;
        waddr = a;
        wdata = d;
        tick();
    endtask

    // mode: 0 strobe held high, 1 every other cycle, 2 random.
    // poke_at: cycle at which a busy-time write and a start pulse are attempted.
    task automatic play(input int l, input bit lp, input int mode, input int stop_at,
                        input int poke_at, input int budget);
        int  n;
        bit  seen;
        start = 1;
        len   = (AWR + 1)'(l);
        loop  = lp;
        stb   = 0;
        tick();
        n    = 0;
        seen = 0;
        while (!seen && n < budget) begin
            case (mode)
                0:       stb = 1;
                1:       stb = (n % 2 == 0);
                default: stb = ($urandom_range(0, 1) == 1);
            endcase
            stop = (n == stop_at);
            if (n == poke_at) begin
                wen   = 1;
                waddr = '0;
                wdata = '1;
                start = 1;
                len   = (AWR + 1)'(5);
            end
            tick();
            n++;
            if (done) seen = 1;
        end
        stb = 0;
        if (!seen) tmo_req++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 0; wdata = '0; waddr = '0; wen = 0; start = 0;
        stop = 0; len = '0; loop = 0; stb = 0;
        #1 reset = 1;
        repeat (3) @(posedge clk);
        #2 reset = 0;
        tick();

        for (int a = 0; a < (1 << AWW); a++) wr(AWW'(a), DWW'($urandom()));
        wr(AWW'(0), DWW'(32'h03020100));
        wr(AWW'(1), DWW'(32'h07060504));

        play(8, 0, 0, -1, -1, 100);
        play(3, 1, 1, 20, -1, 100);
        play(0, 0, 0, -1, 10, 3000);
        play(8, 0, 1, -1, -1, 100);

        start = 1; len = (AWR + 1)'(100); loop = 0; tick();
        stb = 1;
        repeat (10) tick();
        #1 reset = 1;
        stb = 0;
        tick();
        tick();
        reset = 0;
        tick();
        play(8, 0, 0, -1, -1, 100);

        for (int r = 0; r < 12; r++) begin
            int  l;
            bit  lp;
            int  sa;
            repeat ($urandom_range(1, 4)) wr(AWW'($urandom_range(0, (1 << AWW) - 1)), DWW'($urandom()));
            stop = 1; tick();
            start = 1; stop = 1; len = (AWR + 1)'(5); tick();
            l  = int'($urandom_range(1, 40));
            lp = ($urandom_range(0, 1) == 1);
            if (lp) sa = int'($urandom_range(5, 80));
            else if ($urandom_range(0, 1) == 1) sa = int'($urandom_range(0, 30));
            else sa = -1;
            play(l, lp, 2, sa, -1, 400);
        end

        repeat (6) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
